// File: rtl/axilite_master.sv
// rtl/axilite_master.sv - single-outstanding AXI4-Lite initiator driven by a cmd/rsp handshake
//
// Ports:
//   m_axi_aclk, m_axi_areset      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready high only in IDLE)
//   cmd_rnw, cmd_addr,
//   cmd_wdata, cmd_wstrb          command payload (1 = read)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_resp           read data (0 for writes) and BRESP/RRESP
//   busy                          high whenever the FSM is not in IDLE
//   err_count                     saturating count of non-OKAY responses
//   m_axi_aw*/w*/b*/ar*/r*        AXI4-Lite initiator channels
module axilite_master #(
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter int          C_M_AXI_ADDR_WIDTH = 4,
  parameter logic [2:0]  AXI_PROT           = 3'b000
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_areset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              busy,
  output logic [7:0]                        err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awport,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arport,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ, S_RRESP, S_DONE
  } state_t;

  state_t                            state_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic                              awvalid_q, wvalid_q, bready_q;
  logic                              arvalid_q, rready_q;
  logic                              aw_done_q, w_done_q;
  logic                              aw_done_d, w_done_d;
  logic                              rsp_valid_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata_q;
  logic [1:0]                        rsp_resp_q;
  logic [7:0]                        err_count_q;

  // Saturating error counter step for a response being latched.
  function automatic logic [7:0] err_next(input logic [1:0] resp, input logic [7:0] cnt);
    if (resp != 2'b00 && cnt != 8'hFF) return cnt + 8'd1;
    return cnt;
  endfunction

  // A channel counts as done once its handshake has happened, either earlier
  // (sticky flag) or on this very cycle, so AW and W may complete in any order.
  always_comb begin
    aw_done_d = aw_done_q | (awvalid_q & m_axi_awready);
    w_done_d  = w_done_q  | (wvalid_q  & m_axi_wready);
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_count_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            if (cmd_rnw) begin
              arvalid_q <= 1'b1;
              state_q   <= S_READ;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (m_axi_awready) awvalid_q <= 1'b0;
          if (m_axi_wready)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= S_WRESP;
          end
        end
        S_WRESP: begin
          // bready stays high for the whole state so a one-cycle bvalid is never missed.
          if (m_axi_bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= m_axi_bresp;
            rsp_rdata_q <= '0;
            err_count_q <= err_next(m_axi_bresp, err_count_q);
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_READ: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RRESP;
          end
        end
        S_RRESP: begin
          if (m_axi_rvalid) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= m_axi_rresp;
            rsp_rdata_q <= m_axi_rdata;
            err_count_q <= err_next(m_axi_rresp, err_count_q);
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign err_count     = err_count_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awport  = AXI_PROT;
  assign m_axi_arport  = AXI_PROT;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axilite_master.sv
// tb/tb_axilite_master.sv - scoreboard testbench for axilite_master
module tb_axilite_master;

  logic        clk = 1'b0;
  logic        m_axi_areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [7:0]  err_count;
  logic [3:0]  m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awport, m_axi_arport;
  logic        m_axi_awvalid, m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0, m_axi_bready;
  logic        m_axi_arvalid, m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rvalid = 1'b0, m_axi_rready;

  axilite_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4), .AXI_PROT(3'b000)) dut (
    .m_axi_aclk(clk), .m_axi_areset(m_axi_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy), .err_count(err_count),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awport(m_axi_awport),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arport(m_axi_arport),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave configuration: handshake on the Nth cycle of valid; response pulse
  // (always exactly one cycle long) N cycles after the address/data handshakes.
  int         aw_hs = 2, w_hs = 2, ar_hs = 2, b_delay = 1, r_delay = 1;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  logic [31:0] mem [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic [3:0]  s_awaddr = '0, s_araddr = '0, s_wstrb = '0;
  logic [31:0] s_wdata = '0;
  logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (m_axi_areset) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
      m_axi_arready = 0; m_axi_rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (m_axi_bvalid) begin
        m_axi_bvalid = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end
      if (m_axi_rvalid) begin
        m_axi_rvalid = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
      end
      if (m_axi_awready) begin m_axi_awready = 0; aw_got = 1; end
      if (m_axi_wready)  begin m_axi_wready  = 0; w_got  = 1; end
      if (m_axi_arready) begin m_axi_arready = 0; ar_got = 1; end
      if (m_axi_awvalid && !aw_got) begin
        aw_cnt++;
        if (aw_cnt >= aw_hs) begin m_axi_awready = 1; s_awaddr = m_axi_awaddr; end
      end
      if (m_axi_wvalid && !w_got) begin
        w_cnt++;
        if (w_cnt >= w_hs) begin m_axi_wready = 1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; end
      end
      if (m_axi_arvalid && !ar_got) begin
        ar_cnt++;
        if (ar_cnt >= ar_hs) begin m_axi_arready = 1; s_araddr = m_axi_araddr; end
      end
      if (aw_got && w_got && !m_axi_bvalid) begin
        b_cnt++;
        if (b_cnt == 1)
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
        if (b_cnt >= b_delay) begin m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; end
      end
      if (ar_got && !m_axi_rvalid) begin
        r_cnt++;
        if (r_cnt >= r_delay) begin
          m_axi_rvalid = 1; m_axi_rdata = mem[s_araddr[3:2]]; m_axi_rresp = rresp_cfg;
        end
      end
    end
  end

  typedef struct { logic [31:0] rdata; logic [1:0] resp; logic [7:0] err; } exp_t;
  exp_t exp_q[$];
  int   pass_cnt = 0, total_cnt = 0;
  int   acc = 0, last_rsp_cyc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic issue(input logic rnw, input logic [3:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic exp_rsp, input logic [31:0] erd,
                       input logic [1:0] eresp, input logic [7:0] eerr);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st; cmd_valid = 1;
    acc = cyc;
    if (exp_rsp) begin e.rdata = erd; e.resp = eresp; e.err = eerr; exp_q.push_back(e); end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_k(input int k);
    while (cyc < acc + k) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin @(negedge clk); n++; end
    chk("done_timeout", n < 3000, 1);
  endtask

  initial begin
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rsp_valid && rsp_ready) begin
          last_rsp_cyc = cyc;
          if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            chk("err_count", err_count, e.err);
          end
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 6'b0);
    chk("rst_rsp", {rsp_rdata, rsp_resp, err_count}, 42'h0);
    m_axi_areset = 0;

    // Zero-wait write
    issue(0, 4'h4, 32'hDEADBEEF, 4'hF, 1, 32'h0, 2'b00, 8'd0);
    chk("wr_k1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    chk("wr_k1_awaddr", m_axi_awaddr, 4'h4);
    chk("wr_k1_wdata", m_axi_wdata, 32'hDEADBEEF);
    chk("wr_k1_wstrb", m_axi_wstrb, 4'hF);
    chk("wr_awport", m_axi_awport, 3'b000);
    chk("wr_k1_cmd_ready", cmd_ready, 0);
    wait_k(3);
    chk("wr_k3_b_hs", {m_axi_bready, m_axi_bvalid}, 2'b11);
    wait_k(4);
    chk("wr_k4_rsp_valid", rsp_valid, 1);
    wait_done();
    chk("wr_latency", last_rsp_cyc - acc, 4);

    // Read-back
    issue(1, 4'h4, 32'h0, 4'h0, 1, 32'hDEADBEEF, 2'b00, 8'd0);
    chk("rd_k1_arvalid", m_axi_arvalid, 1);
    chk("rd_k1_araddr", m_axi_araddr, 4'h4);
    chk("rd_arport", m_axi_arport, 3'b000);
    wait_done();
    chk("rd_latency", last_rsp_cyc - acc, 4);

    // Split AW/W handshakes with partial strobes
    w_hs = 5;
    issue(0, 4'h8, 32'h12345678, 4'h3, 1, 32'h0, 2'b00, 8'd0);
    wait_k(3);
    chk("split_k3_awvalid", m_axi_awvalid, 0);
    chk("split_k3_wvalid", m_axi_wvalid, 1);
    chk("split_k3_wdata", m_axi_wdata, 32'h12345678);
    wait_k(5);
    chk("split_k5_wvalid", m_axi_wvalid, 1);
    chk("split_k5_wdata", m_axi_wdata, 32'h12345678);
    chk("split_k5_bready", m_axi_bready, 0);
    wait_k(6);
    chk("split_k6_bready", m_axi_bready, 1);
    wait_done();
    w_hs = 2;
    issue(1, 4'h8, 32'h0, 4'h0, 1, 32'h00005678, 2'b00, 8'd0);
    wait_done();

    // Error write response
    bresp_cfg = 2'b10;
    issue(0, 4'hC, 32'hA5A5A5A5, 4'hF, 1, 32'h0, 2'b10, 8'd1);
    wait_done();
    bresp_cfg = 2'b00;

    // Backpressure plus a one-cycle bvalid mid-WRESP
    @(posedge clk); #1 rsp_ready = 0;
    b_delay = 3;
    issue(0, 4'h0, 32'hCAFEF00D, 4'hF, 1, 32'h0, 2'b00, 8'd1);
    wait_k(4);
    chk("bp_k4_wait_b", {m_axi_bready, m_axi_bvalid}, 2'b10);
    wait_k(6);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1;
    wait_done();
    b_delay = 1;
    issue(1, 4'h0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 2'b00, 8'd1);
    wait_done();

    // Error reads until the counter saturates
    rresp_cfg = 2'b10;
    for (int i = 0; i < 256; i++) begin
      issue(1, 4'h0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 2'b10, (2 + i > 255) ? 8'd255 : 8'(2 + i));
      wait_done();
    end
    chk("sat_err_count", err_count, 8'd255);
    rresp_cfg = 2'b00;

    // Reset while waiting in WRESP
    b_delay = 5;
    issue(0, 4'hC, 32'h11111111, 4'hF, 0, 32'h0, 2'b00, 8'd0);
    wait_k(4);
    chk("mid_k4_bready", {busy, m_axi_bready}, 2'b11);
    m_axi_areset = 1;
    @(negedge clk);
    chk("mid_bready", m_axi_bready, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_err_count", err_count, 8'd0);
    m_axi_areset = 0;
    b_delay = 1;
    repeat (3) @(negedge clk);
    issue(1, 4'h4, 32'h0, 4'h0, 1, 32'hDEADBEEF, 2'b00, 8'd0);
    wait_done();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axilite_master.md
Name: axilite_master

Overview:
- Single-outstanding AXI4-Lite initiator.
- Converts a simple command/response interface from local control logic into AXI-Lite write (AW/W/B) and read (AR/R) transactions.
- Drives the team's AXI-Lite register slaves, e.g. GPIO/config register banks.
- One transaction in flight at a time; a saturating counter tracks error responses.

Parameters:
C_M_AXI_DATA_WIDTH, 32, data bus width (32 or 64)
C_M_AXI_ADDR_WIDTH, 4, address bus width
AXI_PROT, 3'b000, constant value driven on m_axi_awport/m_axi_arport

Ports:
m_axi_aclk  in  1  clock
m_axi_areset  in  1  reset; one clock; reset is synchronous and active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_rnw  in  1  1=read, 0=write
cmd_addr  in  C_M_AXI_ADDR_WIDTH  target address
cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data
cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP of completed transaction
busy  out  1  high in any state other than IDLE
err_count  out  8  saturating count of non-OKAY responses
m_axi_awaddr  out  C_M_AXI_ADDR_WIDTH
m_axi_awport  out  3
m_axi_awvalid  out  1
m_axi_awready  in  1
m_axi_wdata  out  C_M_AXI_DATA_WIDTH
m_axi_wstrb  out  C_M_AXI_DATA_WIDTH/8
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
m_axi_araddr  out  C_M_AXI_ADDR_WIDTH
m_axi_arport  out  3
m_axi_arvalid  out  1
m_axi_arready  in  1
m_axi_rdata  in  C_M_AXI_DATA_WIDTH
m_axi_rresp  in  2
m_axi_rvalid  in  1
m_axi_rready  out  1

Behaviour:
- Reset values: all valid/ready outputs 0; addr/data/strb/rsp_rdata/rsp_resp 0; err_count 0; state IDLE.
- All outputs are registered except cmd_ready and busy, which decode from state.
- **FSM states:** IDLE, WRITE, WRESP, READ, RRESP, DONE.
- **IDLE:**
  - cmd_ready=1.
  - On accept: latch addr/wdata/wstrb.
  - rnw=0 -> WRITE; set awvalid=wvalid=1 on the same edge.
  - rnw=1 -> READ; arvalid=1.
- **WRITE:**
  - awvalid and wvalid are asserted together; each holds until its own handshake.
  - Internal aw_done/w_done track completion in either order or the same cycle.
  - Payloads stay stable while valid.
  - When both are done (including on the completing cycle) -> WRESP.
- **WRESP:**
  - bready=1 for every cycle in the state; this covers slaves whose bvalid lasts only one cycle.
  - On bvalid: latch bresp into rsp_resp, rsp_rdata=0, go to DONE.
- **READ:** arvalid held until arready, then go to RRESP with arvalid=0.
- **RRESP:** rready=1; on rvalid latch rdata/rresp, then go to DONE.
- **DONE:**
  - rsp_valid=1, held until rsp_ready, then go to IDLE.
  - cmd_ready=0 in DONE; no back-to-back overlap.
- bvalid/rvalid arriving outside WRESP/RRESP are ignored; bready/rready are 0 there.
- **err_count:** increments by 1 when a response with resp!=2'b00 is latched; saturates at 255.
- **Latency:** against a slave that raises ready one cycle after seeing valid, and valid-response one cycle after the handshake:
  - accept at cycle 0; AW/W valid cycle 1; handshake cycle 2; bvalid+bready cycle 3; rsp_valid cycle 4.
  - Reads follow the same timing.
- **Reset mid-operation:** next edge forces IDLE, clears all valids/readies and rsp_valid; the in-flight response is discarded; err_count is cleared.

Test Plan:
- **Write, zero-wait slave:** cmd write addr=0x4, wdata=0xDEADBEEF, wstrb=4'hF.
  - awaddr=0x4 and wdata=0xDEADBEEF valid at cycle 1.
  - rsp_valid at cycle 4 with rsp_resp=0, rsp_rdata=0, err_count=0.
- **Read-back:** cmd read addr=0x4 after the write above -> araddr=0x4; rsp_rdata=0xDEADBEEF, rsp_resp=0 at cycle 4.
- **Split AW/W handshakes:** awready at cycle 2, wready delayed to cycle 5.
  - awvalid drops after cycle 2; wvalid held through cycle 5 with stable wdata.
  - bready first asserted at cycle 6.
- **Error response plus saturation:** slave returns bresp=2'b10.
  - rsp_resp=2'b10 and err_count increments.
  - 256 consecutive error reads leave err_count=255.
- **Response backpressure plus one-cycle bvalid:** rsp_ready held 0 for 10 cycles.
  - rsp_valid stays 1 and cmd_ready stays 0 throughout.
  - Single-cycle bvalid is captured without loss.
- **Reset mid-transaction:** m_axi_areset=1 while in WRESP -> next cycle bready=0, rsp_valid=0, state IDLE, cmd_ready=1, err_count=0.
